// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges the pipeline stream with a 2-entry long-latency result FIFO into one registered RF write per cycle.
// Latency 1 cycle to rf_*; lu_ready backpressures from registered FIFO count; wb_hold asks the pipeline to yield after STARVE_LIMIT blocked cycles.
module wb_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_wa,
    input  logic [31:0] pipe_wd,
    input  logic        lu_valid,
    output logic        lu_ready,
    input  logic [4:0]  lu_wa,
    input  logic [31:0] lu_wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic [31:0] busy,
    output logic        wb_hold,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [1:0][4:0]  mem_wa;
    logic [1:0][31:0] mem_wd;
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic [2:0]       starve;
    logic [31:0]      busy_q;

    logic        fifo_ne;
    logic        push;
    logic        pipe_ok;
    logic        pop;
    logic [4:0]  head_wa;
    logic [31:0] head_wd;
    logic [2:0]  starve_nxt;
    logic [31:0] busy_nxt;

    // A valid pipeline write always wins, even while wb_hold is raised, so
    // an upstream that ignores the hold never loses data.
    always_comb begin
        fifo_ne  = (count != 2'd0);
        lu_ready = (count != 2'd2);
        push     = lu_valid && lu_ready;
        pipe_ok  = pipe_we && (pipe_wa != 5'd0);
        pop      = fifo_ne && !pipe_ok;
        head_wa  = mem_wa[head];
        head_wd  = mem_wd[head];

        starve_nxt = starve;
        if (!fifo_ne || pop)
            starve_nxt = 3'd0;
        else if (pipe_ok && (starve != LIMIT))
            starve_nxt = starve + 3'd1;

        busy_nxt = busy_q;
        if (pop && (head_wa != 5'd0))
            busy_nxt[head_wa] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0))
            busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    assign busy = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wa  <= '0;
            mem_wd  <= '0;
            head    <= 1'b0;
            tail    <= 1'b0;
            count   <= 2'd0;
            starve  <= 3'd0;
            wb_hold <= 1'b0;
            busy_q  <= '0;
            rf_we   <= 1'b0;
            rf_wa   <= 5'd0;
            rf_wd   <= 32'd0;
        end else begin
            if (push) begin
                mem_wa[tail] <= lu_wa;
                mem_wd[tail] <= lu_wd;
                tail         <= ~tail;
            end
            if (pop)
                head <= ~head;
            count   <= count + {1'b0, push} - {1'b0, pop};
            starve  <= starve_nxt;
            wb_hold <= (starve_nxt == LIMIT);
            busy_q  <= busy_nxt;

            // x0 entries still pop from the FIFO but never reach the RF.
            if (pipe_ok) begin
                rf_we <= 1'b1;
                rf_wa <= pipe_wa;
                rf_wd <= pipe_wd;
            end else if (pop) begin
                rf_we <= (head_wa != 5'd0);
                rf_wa <= head_wa;
                rf_wd <= head_wd;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule
